// File: rtl/hull_fault_pkg.sv
// Shared encodings for the hull fault manager: FSM states, Avalon register
// addresses and CTRL/readback bit positions.
package hull_fault_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CAPTURE = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_CLR_LOCK_BIT = 0;
  localparam int CTRL_CLR_TRIP_BIT = 1;
  localparam int STATUS_SYNC_LSB   = 8;
  localparam int CTRL_TRIP_LSB     = 4;

endpackage

// File: rtl/fault_debounce.sv
// One fault channel: two-flop synchroniser, stability counter, and a rise
// indication aligned with the edge on which the debounced level goes high.
module fault_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Any cycle where sync agrees with the level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_inc_s == CNT_MAX) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_inc_s;
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign sync_o  = sync_q;
  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/hull_fault_manager.sv
// Motor-driver fault supervisor: debounced fault channels, sticky capture,
// trip/hold/lockout sequencing of drv_enable, Avalon-MM register slave.
module hull_fault_manager
  import hull_fault_pkg::*;
#(
  parameter int N_FAULT         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50000,
  parameter int MAX_RETRY       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic [N_FAULT-1:0] fault_in,
  output logic               drv_enable
);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic [N_FAULT-1:0] sync_s;
  logic [N_FAULT-1:0] level_s;
  logic [N_FAULT-1:0] rise_s;
  logic [N_FAULT-1:0] clr_s;
  logic [N_FAULT-1:0] capture_q, capture_d;
  logic [N_FAULT-1:0] mask_q, mask_d;
  state_e             state_q, state_d;
  logic [3:0]         trip_q, trip_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               drv_q, drv_d;
  logic               irq_q, irq_d;
  logic [31:0]        rd_q, rd_d;
  logic               fault_s;
  logic               wr_capture_s, wr_mask_s, wr_ctrl_s;
  logic               unused_s;

  for (genvar g = 0; g < N_FAULT; g++) begin : g_ch
    fault_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .pin_i  (fault_in[g]),
      .sync_o (sync_s[g]),
      .level_o(level_s[g]),
      .rise_o (rise_s[g])
    );
  end

  assign wr_capture_s = write && (address == ADDR_CAPTURE);
  assign wr_mask_s    = write && (address == ADDR_MASK);
  assign wr_ctrl_s    = write && (address == ADDR_CTRL);
  assign fault_s      = |(level_s & mask_q);
  assign unused_s     = ^writedata;

  // A rise on the same edge as a W1C clear keeps the capture bit set.
  always_comb begin
    if (wr_capture_s) begin
      clr_s = writedata[N_FAULT-1:0];
    end else begin
      clr_s = '0;
    end
    capture_d = (capture_q & ~clr_s) | rise_s;
    if (wr_mask_s) begin
      mask_d = writedata[N_FAULT-1:0];
    end else begin
      mask_d = mask_q;
    end
  end

  always_comb begin
    state_d = state_q;
    trip_d  = trip_q;
    hold_d  = hold_q;
    case (state_q)
      RUN: begin
        if (fault_s) begin
          if (trip_q < RETRY_MAX) begin
            state_d = HOLD;
            trip_d  = trip_q + 4'd1;
            hold_d  = '0;
          end else begin
            state_d = LOCKOUT;
          end
        end else begin
          state_d = RUN;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (fault_s) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      LOCKOUT: begin
        if (wr_ctrl_s && writedata[CTRL_CLR_LOCK_BIT]) begin
          state_d = RUN;
          trip_d  = 4'd0;
        end else begin
          state_d = LOCKOUT;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (wr_ctrl_s && writedata[CTRL_CLR_TRIP_BIT]) begin
      trip_d = 4'd0;
    end else begin
      trip_d = trip_d;
    end
    drv_d = (state_d == RUN);
    irq_d = (|(capture_q & mask_q)) | (state_q == LOCKOUT);
  end

  // Readback always uses pre-write register values.
  always_comb begin
    rd_d = 32'd0;
    case (address)
      ADDR_STATUS: begin
        rd_d[N_FAULT-1:0]                 = level_s;
        rd_d[STATUS_SYNC_LSB +: N_FAULT]  = sync_s;
      end
      ADDR_CAPTURE: rd_d[N_FAULT-1:0] = capture_q;
      ADDR_MASK:    rd_d[N_FAULT-1:0] = mask_q;
      ADDR_CTRL: begin
        rd_d[1:0]                 = state_q;
        rd_d[CTRL_TRIP_LSB +: 4]  = trip_q;
      end
      default: rd_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      trip_q    <= 4'd0;
      hold_q    <= '0;
      capture_q <= '0;
      mask_q    <= '0;
      drv_q     <= 1'b1;
      irq_q     <= 1'b0;
      rd_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      trip_q    <= trip_d;
      hold_q    <= hold_d;
      capture_q <= capture_d;
      mask_q    <= mask_d;
      drv_q     <= drv_d;
      irq_q     <= irq_d;
      rd_q      <= rd_d;
    end
  end

  assign readdata   = rd_q;
  assign irq        = irq_q;
  assign drv_enable = drv_q;

endmodule

// File: tb/tb_hull_fault_manager.sv
// Directed and randomized checks of hull_fault_manager against a
// behavioural model built from windowed debounce and timestamped hold.
module tb_hull_fault_manager;
  localparam int NF = 4;
  localparam int DB = 4;
  localparam int HC = 8;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          write = 1'b0;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic          irq;
  logic [NF-1:0] fault_in = '0;
  logic          drv_enable;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hull_fault_manager #(
    .N_FAULT(NF), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .fault_in(fault_in), .drv_enable(drv_enable)
  );

  // Reference model state
  logic [NF-1:0] m_meta, m_sync, m_level, m_cap, m_mask;
  logic [DB-1:0] m_hist [NF];
  int            m_state, m_trip, m_hold_start, m_cyc;
  logic          m_drv, m_irq;
  logic [31:0]   m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_meta = '0; m_sync = '0; m_level = '0; m_cap = '0; m_mask = '0;
    for (int i = 0; i < NF; i++) m_hist[i] = '0;
    m_state = 0; m_trip = 0; m_hold_start = 0; m_cyc = 0;
    m_drv = 1'b1; m_irq = 1'b0; m_rd = 32'd0;
  endtask

  // One clock edge of the model, using the values present before the edge.
  task automatic model_edge();
    logic [NF-1:0] lvl_new;
    logic [NF-1:0] clr;
    logic          fault;
    m_cyc++;
    m_rd = 32'd0;
    case (address)
      2'd0: begin m_rd[NF-1:0] = m_level; m_rd[8 +: NF] = m_sync; end
      2'd1: m_rd[NF-1:0] = m_cap;
      2'd2: m_rd[NF-1:0] = m_mask;
      default: begin m_rd[1:0] = 2'(m_state); m_rd[7:4] = 4'(m_trip); end
    endcase
    m_irq = (|(m_cap & m_mask)) || (m_state == 2);
    fault = |(m_level & m_mask);
    lvl_new = m_level;
    for (int i = 0; i < NF; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], m_sync[i] != m_level[i]};
      if (&m_hist[i]) begin
        lvl_new[i] = ~m_level[i];
        m_hist[i] = '0;
      end
    end
    clr = (write && address == 2'd1) ? writedata[NF-1:0] : '0;
    m_cap = (m_cap & ~clr) | (lvl_new & ~m_level);
    if (write && address == 2'd2) m_mask = writedata[NF-1:0];
    case (m_state)
      0: if (fault) begin
           if (m_trip < MR) begin m_state = 1; m_trip++; m_hold_start = m_cyc; end
           else m_state = 2;
         end
      1: if (m_cyc - m_hold_start == HC) begin
           if (fault) m_hold_start = m_cyc;
           else m_state = 0;
         end
      default: if (write && address == 2'd3 && writedata[0]) begin m_state = 0; m_trip = 0; end
    endcase
    if (write && address == 2'd3 && writedata[1]) m_trip = 0;
    m_level = lvl_new;
    m_sync = m_meta;
    m_meta = fault_in;
    m_drv = (m_state == 0);
  endtask

  task automatic tick(input logic [NF-1:0] pins, input logic [1:0] addr,
                      input logic wr, input logic [31:0] wd);
    fault_in = pins; address = addr; write = wr; writedata = wd;
    @(posedge clk);
    model_edge();
    #1;
    check("drv_enable", {31'd0, drv_enable}, {31'd0, m_drv});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("readdata", readdata, m_rd);
    write = 1'b0;
  endtask

  initial begin
    int            rel_t;
    logic [NF-1:0] pins_r;
    logic [1:0]    a_r;
    logic          w_r;
    logic [31:0]   d_r;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check("rst_drv", {31'd0, drv_enable}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      tick(4'h0, 2'(a), 1'b0, 32'd0);
      check("rst_reg", readdata, 32'd0);
    end

    // Glitch rejection, then a long pulse
    for (int t = 1; t <= 3; t++) tick(4'h1, 2'd0, 1'b0, 32'd0);
    for (int t = 1; t <= 8; t++) tick(4'h0, 2'd0, 1'b0, 32'd0);
    check("glitch_status", readdata, 32'd0);
    tick(4'h0, 2'd1, 1'b0, 32'd0);
    check("glitch_capture", readdata, 32'd0);
    check("glitch_drv", {31'd0, drv_enable}, 32'd1);
    for (int t = 1; t <= 10; t++) begin
      tick(4'h1, 2'd0, 1'b0, 32'd0);
      if (t == 6) check("status_sync_only", readdata, 32'h100);
      if (t == 7) check("status_level", readdata, 32'h101);
    end
    for (int t = 1; t <= 10; t++) tick(4'h0, 2'd0, 1'b0, 32'd0);
    tick(4'h0, 2'd1, 1'b0, 32'd0);
    check("capture_set", readdata, 32'h1);
    check("unmasked_irq", {31'd0, irq}, 32'd0);
    tick(4'h0, 2'd1, 1'b1, 32'h1);
    tick(4'h0, 2'd1, 1'b0, 32'd0);
    check("capture_w1c", readdata, 32'd0);

    // Trip and hold
    tick(4'h0, 2'd2, 1'b1, 32'h1);
    for (int t = 1; t <= 10; t++) begin
      tick(4'h1, 2'd3, 1'b0, 32'd0);
      if (t == 6) check("drv_before_trip", {31'd0, drv_enable}, 32'd1);
      if (t == 7) check("drv_after_trip", {31'd0, drv_enable}, 32'd0);
      if (t == 9) check("hold_ctrl", readdata, 32'h11);
    end
    rel_t = -1;
    for (int t = 1; t <= 40; t++) begin
      tick(4'h0, 2'd3, 1'b0, 32'd0);
      if (drv_enable && rel_t < 0) rel_t = t;
    end
    check("hold_release", rel_t, 32'd13);
    tick(4'h0, 2'd3, 1'b0, 32'd0);
    check("trip_after_hold", readdata, 32'h10);

    // Sustained fault keeps restarting the hold
    tick(4'h0, 2'd3, 1'b1, 32'h2);
    for (int t = 1; t <= 40; t++) begin
      tick(4'h1, 2'd3, 1'b0, 32'd0);
      if (t >= 8) begin
        check("sustain_drv", {31'd0, drv_enable}, 32'd0);
        check("sustain_ctrl", readdata, 32'h11);
      end
    end
    for (int t = 1; t <= 40; t++) tick(4'h0, 2'd3, 1'b0, 32'd0);
    check("sustain_release", {31'd0, drv_enable}, 32'd1);

    // Lockout after MAX_RETRY re-enables
    tick(4'h0, 2'd3, 1'b1, 32'h2);
    for (int n = 0; n < 3; n++) begin
      for (int t = 1; t <= 10; t++) tick(4'h1, 2'd3, 1'b0, 32'd0);
      for (int t = 1; t <= 30; t++) tick(4'h0, 2'd3, 1'b0, 32'd0);
    end
    check("lockout_ctrl", readdata, 32'h22);
    check("lockout_irq", {31'd0, irq}, 32'd1);
    check("lockout_drv", {31'd0, drv_enable}, 32'd0);
    tick(4'h0, 2'd3, 1'b1, 32'h1);
    check("lockout_read_prewrite", readdata, 32'h22);
    check("lockout_clear_drv", {31'd0, drv_enable}, 32'd1);
    tick(4'h0, 2'd3, 1'b0, 32'd0);
    check("lockout_clear_ctrl", readdata, 32'd0);

    // Capture set beats a simultaneous W1C; unmasked channel never trips
    tick(4'h0, 2'd1, 1'b1, 32'hF);
    for (int t = 1; t <= 10; t++) begin
      tick(4'h4, 2'd1, (t == 6), 32'h4);
      if (t == 8) check("w1c_race", readdata, 32'h4);
    end
    for (int t = 1; t <= 12; t++) tick(4'h0, 2'd1, 1'b0, 32'd0);
    for (int t = 1; t <= 10; t++) tick(4'h8, 2'd1, 1'b0, 32'd0);
    for (int t = 1; t <= 12; t++) tick(4'h0, 2'd1, 1'b0, 32'd0);
    check("cap3_rd", readdata, 32'hC);
    check("cap3_irq", {31'd0, irq}, 32'd0);
    check("cap3_drv", {31'd0, drv_enable}, 32'd1);

    // Randomized traffic
    pins_r = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 15) == 0) pins_r[i] = ~pins_r[i];
      a_r = 2'($urandom_range(0, 3));
      w_r = ($urandom_range(0, 7) == 0);
      d_r = $urandom;
      if (w_r && a_r == 2'd3)
        d_r[1:0] = (m_state == 0) ? 2'b01 : 2'($urandom_range(1, 3));
      tick(pins_r, a_r, w_r, d_r);
    end

    // Reset in the middle of a hold
    for (int t = 1; t <= 30; t++) tick(4'h0, 2'd3, 1'b0, 32'd0);
    tick(4'h0, 2'd3, 1'b1, 32'h3);
    tick(4'h0, 2'd2, 1'b1, 32'h1);
    for (int t = 1; t <= 8; t++) tick(4'h1, 2'd3, 1'b0, 32'd0);
    check("pre_reset_hold", {31'd0, drv_enable}, 32'd0);
    fault_in = '0;
    reset = 1'b1;
    #1;
    check("async_drv", {31'd0, drv_enable}, 32'd1);
    check("async_rdata", readdata, 32'd0);
    check("async_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      tick(4'h0, 2'(a), 1'b0, 32'd0);
      check("post_reset_reg", readdata, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
